// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand sequencer: default sizes, operand
// select codes and sequencer state encodings.
package rsa_pkg;

    localparam int DEFAULT_DATA_WIDTH   = 32;
    localparam int DEFAULT_WORDS_PER_OP = 32;

    typedef enum logic [1:0] {
        OP_M = 2'd0,
        OP_P = 2'd1,
        OP_Q = 2'd2,
        OP_E = 2'd3
    } op_sel_t;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3
    } seq_state_t;

endpackage

// File: rtl/rsa_operand_sequencer_if.sv
// Bundle of UART-side, operand-buffer, engine and result signals around the
// sequencer; master is the sequencer itself, slave is its environment.
interface rsa_operand_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 5
);
    logic [7:0]            rx_byte;
    logic                  rx_valid;
    logic                  wr_en;
    logic [1:0]            wr_sel;
    logic [AW-1:0]         wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  eng_start;
    logic                  eng_done;
    logic                  result_valid;
    logic                  result_ack;
    logic                  rx_dropped;
    logic [2:0]            state;

    modport master (
        input  rx_byte, rx_valid, eng_done, result_ack,
        output wr_en, wr_sel, wr_addr, wr_data, eng_start,
               result_valid, rx_dropped, state
    );

    modport slave (
        output rx_byte, rx_valid, eng_done, result_ack,
        input  wr_en, wr_sel, wr_addr, wr_data, eng_start,
               result_valid, rx_dropped, state
    );
endinterface

// File: rtl/rsa_byte_packer.sv
// Packs bytes MSB-first into words; the finished word is copied into a separate
// output register so the shift register can keep accepting a byte every cycle.
module rsa_byte_packer
    import rsa_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            rx_byte,
    output logic                  word_valid,
    output logic [DATA_WIDTH-1:0] word
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int CW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_WORD - 1);

    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] next_shift;

    assign next_shift = (shift << 8) | DATA_WIDTH'(rx_byte);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            shift      <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                count <= '0;
                shift <= '0;
            end else if (accept) begin
                shift <= next_shift;
                if (count == LAST_BYTE) begin
                    count      <= '0;
                    word       <= next_shift;
                    word_valid <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rsa_operand_sequencer.sv
// Loads M, P, Q, E into the operand buffer from the UART byte stream, kicks the
// exponentiation engine and holds the result handshake until acknowledged.
module rsa_operand_sequencer
    import rsa_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int WORDS_PER_OP = DEFAULT_WORDS_PER_OP
) (
    input  logic                     clk,
    input  logic                     reset,
    rsa_operand_sequencer_if.master  bus
);
    localparam int AW = $clog2(WORDS_PER_OP);
    localparam logic [AW-1:0] LAST_IDX = AW'(WORDS_PER_OP - 1);

    seq_state_t            state_q;
    op_sel_t               op_sel;
    logic [AW-1:0]         word_idx;
    logic                  eng_start_q;
    logic                  result_valid_q;
    logic                  rx_dropped_q;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic                  accept;
    logic                  clear;

    assign accept = bus.rx_valid && (state_q == ST_LOAD);
    assign clear  = (state_q == ST_DONE) && bus.result_ack;

    rsa_byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .accept     (accept),
        .rx_byte    (bus.rx_byte),
        .word_valid (word_valid),
        .word       (word)
    );

    // Word index and operand select point at the word currently on the write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_LOAD;
            op_sel         <= OP_M;
            word_idx       <= '0;
            eng_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            rx_dropped_q   <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            if (bus.rx_valid && (state_q != ST_LOAD)) begin
                rx_dropped_q <= 1'b1;
            end
            case (state_q)
                ST_LOAD: begin
                    if (word_valid) begin
                        if (word_idx == LAST_IDX) begin
                            word_idx <= '0;
                            if (op_sel == OP_E) begin
                                op_sel      <= OP_M;
                                state_q     <= ST_START;
                                eng_start_q <= 1'b1;
                            end else begin
                                op_sel <= op_sel_t'(op_sel + 2'd1);
                            end
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.eng_done) begin
                        state_q        <= ST_DONE;
                        result_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.result_ack) begin
                        state_q        <= ST_LOAD;
                        result_valid_q <= 1'b0;
                        op_sel         <= OP_M;
                        word_idx       <= '0;
                    end
                end
                default: begin
                    state_q        <= ST_LOAD;
                    result_valid_q <= 1'b0;
                    op_sel         <= OP_M;
                    word_idx       <= '0;
                end
            endcase
        end
    end

    assign bus.wr_en        = word_valid && (state_q == ST_LOAD);
    assign bus.wr_sel       = op_sel;
    assign bus.wr_addr      = word_idx;
    assign bus.wr_data      = word;
    assign bus.eng_start    = eng_start_q;
    assign bus.result_valid = result_valid_q;
    assign bus.rx_dropped   = rx_dropped_q;
    assign bus.state        = state_q;

endmodule

// File: tb/tb_rsa_operand_sequencer.sv
// Directed bench for rsa_operand_sequencer with a message-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_rsa_operand_sequencer;

    localparam int DW  = 32;
    localparam int WPO = 2;
    localparam int AWB = 1;
    localparam int BPW = DW / 8;
    localparam int TOTAL_WORDS = 4 * WPO;

    logic clk;
    logic reset;

    rsa_operand_sequencer_if #(.DATA_WIDTH(DW), .AW(AWB)) bus ();

    rsa_operand_sequencer #(
        .DATA_WIDTH   (DW),
        .WORDS_PER_OP (WPO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks accepted bytes per message and derives each write
    // from the running byte total; phases follow LOAD/START/WAIT/DONE.
    bit          model_live = 0;
    int          phase = 0;
    int          nbytes = 0;
    bit          last_pending = 0;
    bit          prev_pending;
    int          prev_phase;
    int          widx;
    logic [7:0]  msg[$];
    logic        e_wr_en = 0;
    logic [1:0]  e_sel = 0;
    logic [AWB-1:0] e_addr = 0;
    logic [DW-1:0]  e_data = 0;
    logic        e_start = 0;
    logic        e_rv = 0;
    logic        e_drop = 0;

    always @(posedge clk) begin
        model_live = 1;
        if (!reset) begin
            phase = 0; nbytes = 0; last_pending = 0; msg.delete();
            e_wr_en = 0; e_start = 0; e_rv = 0; e_drop = 0;
        end else begin
            prev_phase   = phase;
            prev_pending = last_pending;
            last_pending = 0;
            e_wr_en = 0;
            e_start = 0;
            if (bus.rx_valid) begin
                if (prev_phase == 0) begin
                    msg.push_back(bus.rx_byte);
                    nbytes++;
                    if (nbytes % BPW == 0) begin
                        widx    = nbytes / BPW - 1;
                        e_wr_en = 1;
                        e_sel   = 2'(widx / WPO);
                        e_addr  = AWB'(widx % WPO);
                        e_data  = {msg[nbytes-4], msg[nbytes-3], msg[nbytes-2], msg[nbytes-1]};
                        if (widx == TOTAL_WORDS - 1) last_pending = 1;
                    end
                end else begin
                    e_drop = 1;
                end
            end
            case (prev_phase)
                0: if (prev_pending) begin phase = 1; e_start = 1; end
                1: phase = 2;
                2: if (bus.eng_done) begin phase = 3; e_rv = 1; end
                3: if (bus.result_ack) begin phase = 0; e_rv = 0; nbytes = 0; msg.delete(); end
                default: phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check_output("cyc_wr_en", 64'(bus.wr_en), 64'(e_wr_en));
            check_output("cyc_eng_start", 64'(bus.eng_start), 64'(e_start));
            check_output("cyc_result_valid", 64'(bus.result_valid), 64'(e_rv));
            check_output("cyc_rx_dropped", 64'(bus.rx_dropped), 64'(e_drop));
            check_output("cyc_state", 64'(bus.state), 64'(phase));
            if (e_wr_en) begin
                check_output("cyc_wr_sel", 64'(bus.wr_sel), 64'(e_sel));
                check_output("cyc_wr_addr", 64'(bus.wr_addr), 64'(e_addr));
                check_output("cyc_wr_data", 64'(bus.wr_data), 64'(e_data));
            end
        end
    end

    // Write log and start-pulse timing, used by the literal checks.
    typedef struct packed {
        logic [1:0]     sel;
        logic [AWB-1:0] addr;
        logic [DW-1:0]  data;
    } wr_rec_t;

    wr_rec_t wr_log[$];
    int cyc = 0;
    int start_count = 0;
    int start_cyc = 0;
    int last_wr_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (model_live && bus.wr_en === 1'b1) begin
            wr_log.push_back('{sel: bus.wr_sel, addr: bus.wr_addr, data: bus.wr_data});
            last_wr_cyc = cyc;
        end
        if (model_live && bus.eng_start === 1'b1) begin
            start_count++;
            start_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int gap);
        bus.rx_byte  = b;
        bus.rx_valid = 1'b1;
        step();
        bus.rx_valid = 1'b0;
        repeat (gap) step();
    endtask

    logic [DW-1:0] burst_words [TOTAL_WORDS] = '{
        32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
        32'h10111213, 32'h14151617, 32'h18191A1B, 32'h1C1D1E1F
    };

    initial begin
        reset = 1'b0;
        bus.rx_byte = 8'h00;
        bus.rx_valid = 1'b0;
        bus.eng_done = 1'b0;
        bus.result_ack = 1'b0;
        step();
        step();
        check_output("rst_state", 64'(bus.state), 64'd0);
        check_output("rst_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("rst_wr_data", 64'(bus.wr_data), 64'd0);
        check_output("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_output("rst_eng_start", 64'(bus.eng_start), 64'd0);
        check_output("rst_result_valid", 64'(bus.result_valid), 64'd0);
        check_output("rst_rx_dropped", 64'(bus.rx_dropped), 64'd0);
        reset = 1'b1;
        step();

        // Spaced bytes form one word, written one cycle after the last strobe.
        wr_log.delete();
        apply_stimulus(8'hDE, 2);
        apply_stimulus(8'hAD, 2);
        apply_stimulus(8'hBE, 2);
        apply_stimulus(8'hEF, 0);
        check_output("t1_wr_en_latency", 64'(bus.wr_en), 64'd1);
        check_output("t1_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
        step();
        check_output("t1_wr_en_single", 64'(bus.wr_en), 64'd0);
        check_output("t1_log_size", 64'(wr_log.size()), 64'd1);
        if (wr_log.size() > 0) begin
            check_output("t1_log_sel", 64'(wr_log[0].sel), 64'd0);
            check_output("t1_log_addr", 64'(wr_log[0].addr), 64'd0);
        end

        // Fresh message streamed with a strobe on every cycle.
        reset = 1'b0;
        step();
        reset = 1'b1;
        wr_log.delete();
        start_count = 0;
        for (int k = 0; k < TOTAL_WORDS * BPW; k++) begin
            bus.rx_byte  = 8'(k);
            bus.rx_valid = 1'b1;
            step();
        end
        bus.rx_valid = 1'b0;
        repeat (4) step();
        check_output("t2_log_size", 64'(wr_log.size()), 64'd8);
        for (int i = 0; i < TOTAL_WORDS; i++) begin
            if (i < wr_log.size()) begin
                check_output("t2_sel", 64'(wr_log[i].sel), 64'(i / 2));
                check_output("t2_addr", 64'(wr_log[i].addr), 64'(i % 2));
                check_output("t2_data", 64'(wr_log[i].data), 64'(burst_words[i]));
            end
        end
        check_output("t2_start_count", 64'(start_count), 64'd1);
        check_output("t2_start_delay", 64'(start_cyc - last_wr_cyc), 64'd1);
        check_output("t2_state_wait", 64'(bus.state), 64'd2);

        // Byte in WAIT is dropped and leaves the FSM alone.
        apply_stimulus(8'h55, 1);
        check_output("t4_rx_dropped", 64'(bus.rx_dropped), 64'd1);
        check_output("t4_no_write", 64'(wr_log.size()), 64'd8);
        check_output("t4_state", 64'(bus.state), 64'd2);

        // Ack outside DONE is ignored.
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        step();
        check_output("t6_ack_in_wait_state", 64'(bus.state), 64'd2);
        check_output("t6_ack_in_wait_rv", 64'(bus.result_valid), 64'd0);

        // Done -> result held -> ack re-arms.
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        check_output("t3_rv_set", 64'(bus.result_valid), 64'd1);
        check_output("t3_state_done", 64'(bus.state), 64'd3);
        repeat (5) step();
        check_output("t3_rv_held", 64'(bus.result_valid), 64'd1);
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        check_output("t3_rv_clear", 64'(bus.result_valid), 64'd0);
        check_output("t3_state_load", 64'(bus.state), 64'd0);
        check_output("t4_drop_sticky", 64'(bus.rx_dropped), 64'd1);

        // Done outside WAIT is ignored.
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        step();
        check_output("t6_done_in_load_state", 64'(bus.state), 64'd0);
        check_output("t6_done_in_load_rv", 64'(bus.result_valid), 64'd0);

        // Reset mid-message discards the partial word.
        wr_log.delete();
        for (int k = 0; k < 2 * BPW + 2; k++) begin
            bus.rx_byte  = 8'hA0 + 8'(k);
            bus.rx_valid = 1'b1;
            step();
        end
        bus.rx_valid = 1'b0;
        check_output("t5_pre_writes", 64'(wr_log.size()), 64'd2);
        reset = 1'b0;
        step();
        check_output("t5_rst_wr_en", 64'(bus.wr_en), 64'd0);
        check_output("t5_rst_wr_data", 64'(bus.wr_data), 64'd0);
        check_output("t5_rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_output("t5_rst_wr_sel", 64'(bus.wr_sel), 64'd0);
        check_output("t5_rst_drop", 64'(bus.rx_dropped), 64'd0);
        check_output("t5_rst_state", 64'(bus.state), 64'd0);
        reset = 1'b1;
        for (int k = 1; k <= BPW; k++) begin
            bus.rx_byte  = 8'(k);
            bus.rx_valid = 1'b1;
            step();
        end
        bus.rx_valid = 1'b0;
        check_output("t5_wr_en", 64'(bus.wr_en), 64'd1);
        check_output("t5_wr_sel", 64'(bus.wr_sel), 64'd0);
        check_output("t5_wr_addr", 64'(bus.wr_addr), 64'd0);
        check_output("t5_wr_data", 64'(bus.wr_data), 64'h01020304);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
